router_pkt_fifo: RTL and testbench

- Parametrised packet-aware FIFO for the router output channels; next generation of the fixed 16x8 router FIFO.
- Each entry stores a data byte plus a header (start-of-packet) flag.
- Read side tracks the header length field to mark end-of-packet, and exposes fill level plus almost-full/almost-empty watermarks.
- Sits between the router FSM/synchronizer (write side) and each destination read port.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_fifo_ram.sv | 30 +++
 rtl/router_pkt_fifo.sv | 103 ++++++++++
 tb/tb_router_pkt_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and defaults for the router output-channel packet FIFO.
// The header length field sits in bits [LEN_LSB +: LEN_W] of a header byte.
package router_pkg;

  localparam int DATA_W  = 8;
  localparam int LEN_LSB = 2;
  localparam int LEN_W   = 6;

  typedef struct packed {
    logic              sop;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // Payload length L carried by a header byte.
  function automatic int unsigned hdr_len(input logic [DATA_W-1:0] hdr);
    return int'((hdr >> LEN_LSB) & DATA_W'((1 << LEN_W) - 1));
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: synchronous write, registered read.
// Only the read register is cleared; the array itself carries no reset.
module router_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left unreset so it maps onto RAM macros;
  // unwritten entries are never read because the empty flag blocks them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (clr)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO: byte + start-of-packet flag per entry,
// end-of-packet tracking from the header length field, level and watermarks.
module router_pkt_fifo #(
  parameter int DATA_W    = router_pkg::DATA_W,
  parameter int DEPTH     = 16,
  parameter int LEN_LSB   = router_pkg::LEN_LSB,
  parameter int LEN_W     = router_pkg::LEN_W,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_rst,
  input  logic                   wr_en,
  input  logic                   sop_in,
  input  logic [DATA_W-1:0]      din,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      dout,
  output logic                   dout_valid,
  output logic                   dout_sop,
  output logic                   dout_eop,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   pkt_active,
  output logic                   len_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = LEN_W + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [RW-1:0] rem_q, rem_now;
  logic          clear, wr_acc, rd_acc, rd_sop;
  logic [DATA_W:0] rd_word;

  assign clear  = !rst || soft_rst;
  assign wr_acc = wr_en && !full && !soft_rst;
  assign rd_acc = rd_en && !empty && !soft_rst;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign almost_full  = (level >= PW'(AF_THRESH));
  assign almost_empty = (level <= PW'(AE_THRESH));

  router_fifo_ram #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .clr     (clear),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({sop_in, din}),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  assign {rd_sop, dout} = rd_word;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rem_q      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
      rem_q      <= rem_now;
      dout_valid <= rd_acc;
    end
  end

  // rem_q is the remaining count before the byte now on dout; the framing
  // effect of that byte is applied here and committed on the next edge.
  // NOTE: rem_now gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    rem_now = rem_q;
    if (dout_valid) begin
      if (rd_sop)              rem_now = RW'(dout[LEN_LSB +: LEN_W]) + RW'(1);
      else if (rem_q != '0)    rem_now = rem_q - RW'(1);
    end
  end

  assign dout_sop   = dout_valid && rd_sop;
  assign dout_eop   = dout_valid && !rd_sop && (rem_q == RW'(1));
  assign len_err    = dout_valid && (rd_sop ? (rem_q != '0) : (rem_q == '0));
  assign pkt_active = (rem_now != '0);

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: directed scenarios plus random
// traffic, all checked against a queue-based packet model.
module tb_router_pkt_fifo;
  import router_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0, soft_rst = 1'b0, wr_en = 1'b0, sop_in = 1'b0, rd_en = 1'b0;
  logic [7:0]    din = '0;
  logic [7:0]    dout;
  logic          dout_valid, dout_sop, dout_eop, full, empty, almost_full, almost_empty;
  logic          pkt_active, len_err;
  logic [LW-1:0] level;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  fifo_entry_t   q[$];
  int unsigned   m_rem = 0;
  logic [7:0]    m_dout = '0;
  logic          m_valid = 1'b0, m_sop = 1'b0, m_eop = 1'b0, m_err = 1'b0;

  router_pkt_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en), .sop_in(sop_in),
    .din(din), .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .pkt_active(pkt_active), .len_err(len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] exp_vec();
    int sz = q.size();
    return {m_dout, m_valid, m_sop, m_eop, m_err, (m_rem != 0), LW'(sz),
            (sz == DEPTH), (sz == 0), (sz >= DEPTH - 2), (sz <= 2)};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {dout, dout_valid, dout_sop, dout_eop, len_err, pkt_active, level,
            full, empty, almost_full, almost_empty};
  endfunction

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit w, input bit s, input logic [7:0] d, input bit r, input bit sr);
    int sz;
    bit cw, cr;
    fifo_entry_t e;
    @(negedge clk);
    wr_en = w; sop_in = s; din = d; rd_en = r; soft_rst = sr;
    sz = q.size();
    cw = w && (sz < DEPTH) && !sr;
    cr = r && (sz > 0) && !sr;
    m_valid = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0;
    if (sr) begin
      q.delete();
      m_rem  = 0;
      m_dout = '0;
    end
    if (cr) begin
      e = q.pop_front();
      m_dout = e.data; m_sop = e.sop; m_valid = 1'b1;
      if (e.sop) begin
        m_err = (m_rem != 0);
        m_rem = hdr_len(e.data) + 1;
      end else if (m_rem > 0) begin
        m_eop = (m_rem == 1);
        m_rem--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (cw) begin
      e.sop = s; e.data = d;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; soft_rst = 1'b0; sop_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    q.delete(); m_rem = 0; m_dout = '0;
    m_valid = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0;
    n_checks++;
    if ({dout, dout_valid, level, empty, full, pkt_active, len_err} !== {8'h00, 1'b0, LW'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got dout=%h valid=%b level=%0d empty=%b full=%b act=%b err=%b, want 00/0/0/1/0/0/0",
               dout, dout_valid, level, empty, full, pkt_active, len_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_packet();
    logic [7:0] pkt [5] = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h55};
    for (int i = 0; i < 5; i++) step(1, i == 0, pkt[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 1, 0);
      n_checks++;
      if ({dout, dout_valid, dout_sop, dout_eop} !== {pkt[i], 1'b1, i == 0, i == 4}) begin
        n_errors++;
        $display("FAIL basic_read[%0d]: got dout=%h v=%b sop=%b eop=%b, want %h/1/%b/%b",
                 i, dout, dout_valid, dout_sop, dout_eop, pkt[i], i == 0, i == 4);
      end
    end
    n_checks++;
    if (pkt_active !== 1'b0 || len_err !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_pkt_end: got pkt_active=%b len_err=%b, want 0/0", pkt_active, len_err);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 8'($urandom), 0, 0);
      n_checks++;
      if ({level, almost_full, full} !== {LW'(i + 1), (i + 1) >= 14, (i + 1) == DEPTH}) begin
        n_errors++;
        $display("FAIL fill[%0d]: got level=%0d af=%b full=%b, want %0d/%b/%b",
                 i, level, almost_full, full, i + 1, (i + 1) >= 14, (i + 1) == DEPTH);
      end
    end
    step(1, 0, 8'hEE, 0, 0);
    n_checks++;
    if (level !== LW'(16) || full !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_drop: got level=%0d full=%b, want 16/1", level, full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 8'h00, 1, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL drain[%0d]: got %h, want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom), 0, 0);
    step(1, 0, 8'hBB, 1, 0);
    n_checks++;
    if (level !== LW'(15) || dout_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL full_rw: got level=%0d vec=%h, want 15/%h", level, obs_vec(), exp_vec());
    end
    for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0);
    step(1, 0, 8'h5A, 1, 0);
    n_checks++;
    if (level !== LW'(1) || dout_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL empty_rw: got level=%0d valid=%b, want 1/0", level, dout_valid);
    end
    step(0, 0, 8'h00, 1, 0);
    n_checks++;
    if (dout !== 8'h5A || empty !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_rw_readback: got dout=%h empty=%b, want 5a/1", dout, empty);
    end
  endtask

  task automatic test_soft_rst();
    step(1, 1, 8'h0C, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    n_checks++;
    if (pkt_active !== 1'b1 || level !== LW'(2)) begin
      n_errors++;
      $display("FAIL pre_soft_rst: got pkt_active=%b level=%0d, want 1/2", pkt_active, level);
    end
    step(1, 0, 8'h99, 1, 1);
    n_checks++;
    if ({level, empty, dout, dout_valid, pkt_active} !== {LW'(0), 1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL soft_rst: got level=%0d empty=%b dout=%h v=%b act=%b, want 0/1/00/0/0",
               level, empty, dout, dout_valid, pkt_active);
    end
  endtask

  task automatic test_len_err();
    step(1, 0, 8'h33, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    n_checks++;
    if ({dout, len_err, dout_eop} !== {8'h33, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL len_err_pulse: got dout=%h err=%b eop=%b, want 33/1/0", dout, len_err, dout_eop);
    end
    step(0, 0, 8'h00, 0, 0);
    n_checks++;
    if (len_err !== 1'b0 || dout !== 8'h33) begin
      n_errors++;
      $display("FAIL len_err_clear: got err=%b dout=%h, want 0/33", len_err, dout);
    end
  endtask

  task automatic test_zero_len();
    step(1, 1, 8'h00, 0, 0);
    step(1, 0, 8'h77, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    n_checks++;
    if ({dout_sop, dout_eop, pkt_active} !== {1'b1, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL zero_len_hdr: got sop=%b eop=%b act=%b, want 1/0/1", dout_sop, dout_eop, pkt_active);
    end
    step(0, 0, 8'h00, 1, 0);
    n_checks++;
    if ({dout, dout_eop, pkt_active, len_err} !== {8'h77, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL zero_len_eop: got dout=%h eop=%b act=%b err=%b, want 77/1/0/0",
               dout, dout_eop, pkt_active, len_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit w  = ($urandom_range(0, 99) < 55);
      bit r  = ($urandom_range(0, 99) < 50);
      bit s  = ($urandom_range(0, 3) == 0);
      bit sr = ($urandom_range(0, 99) < 2);
      logic [7:0] d = 8'($urandom);
      if (s) d[7:LEN_LSB] = 6'($urandom_range(0, 4));
      step(w, s, d, r, sr);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h, want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_fill();
    test_simultaneous();
    test_soft_rst();
    test_len_err();
    test_zero_len();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
